// File: rtl/mp_add_seq_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
package mp_add_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } st_t;

   // Slice index width; a single-slice configuration still needs one bit.
   function automatic int unsigned idx_w(input int unsigned k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Requester/consumer handshake bundle for mp_add_seq.
interface mp_add_seq_if #(
   parameter int unsigned N = 8,
   parameter int unsigned K = 4
);
   localparam int unsigned W = N * K;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;

   modport master (
      output in_valid, a, b, op_sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, op_sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );

endinterface

// File: rtl/mp_add_seq_cpa.sv
// N-bit carry-propagate adder slice.
module CPA #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one N-bit CPA slice reused over K cycles,
// LS slice first, carry registered between slices.
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned K = 4
) (
   input  logic        clk,
   input  logic        reset,
   mp_add_seq_if.slave bus
);

   localparam int unsigned W  = N * K;
   localparam int unsigned IW = idx_w(K);
   localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   st_t          state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] sum_q, sum_d;
   logic         carry_q, carry_d;
   logic         cout_q, cout_d;
   logic         ovf_q, ovf_d;

   logic [BW-1:0] base;
   logic [N-1:0]  a_sl, b_sl, s_sl;
   logic          c_sl;

   assign base = BW'(32'(idx_q) * N);
   assign a_sl = a_q[base +: N];
   assign b_sl = b_q[base +: N];

   CPA #(.N(N)) u_cpa (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .s    (s_sl),
      .cout (c_sl)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               // Subtract folds into the add: invert B here, inject +1 as carry-in.
               a_d     = bus.a;
               b_d     = bus.b ^ {W{bus.op_sub}};
               carry_d = bus.op_sub;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[base +: N] = s_sl;
            carry_d          = c_sl;
            if (idx_q == LAST) begin
               idx_d   = '0;
               cout_d  = c_sl;
               ovf_d   = (a_sl[N-1] == b_sl[N-1]) && (s_sl[N-1] != a_sl[N-1]);
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq (N=8, K=4).
module tb_mp_add_seq;

   localparam int unsigned N = 8;
   localparam int unsigned K = 4;
   localparam int unsigned W = N * K;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mp_add_seq_if #(.N(N), .K(K)) bus ();

   mp_add_seq #(.N(N), .K(K)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum  = s;
      e.cout = c;
      e.ovf  = o;
      return e;
   endfunction

   // Reference from integer arithmetic: signed range check for ovf, unsigned compare for cout.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t   e;
      longint ua, ub, sa, sbv, ideal, lim;
      ua    = longint'({32'd0, a});
      ub    = longint'({32'd0, b});
      sa    = longint'($signed(a));
      sbv   = longint'($signed(b));
      lim   = longint'(64'd1) << (W - 1);
      ideal = sub ? (sa - sbv) : (sa + sbv);
      e.sum  = sub ? (a - b) : (a + b);
      e.cout = sub ? (ua >= ub) : ((ua + ub) >= (longint'(64'd1) << W));
      e.ovf  = (ideal >= lim) || (ideal < -lim);
      return e;
   endfunction

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input exp_t e);
      int unsigned t;
      bus.a        = a;
      bus.b        = b;
      bus.op_sub   = sub;
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
      end
      @(posedge clk);
      sb.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.op_sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic collect(input int unsigned hold);
      int unsigned n;
      exp_t e;
      n = 0;
      while (!bus.out_valid && n < 4 * K + 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== K) begin
         errors++;
         $display("FAIL latency: got %0d cycles, required %0d", n, K);
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: size=0 required >0");
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      checks++;
      if (bus.sum !== e.sum) begin
         errors++;
         $display("FAIL sum: got %h required %h", bus.sum, e.sum);
      end
      checks++;
      if (bus.cout !== e.cout) begin
         errors++;
         $display("FAIL cout: got %b required %b", bus.cout, e.cout);
      end
      checks++;
      if (bus.ovf !== e.ovf) begin
         errors++;
         $display("FAIL ovf: got %b required %b", bus.ovf, e.ovf);
      end
      repeat (hold) begin
         @(negedge clk);
         checks++;
         if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL hold_stable: got v=%b s=%h c=%b o=%b required v=1 s=%h c=%b o=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
         end
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_ready: got %b required 0", bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL after_handshake: got out_valid=%b in_ready=%b required 0/1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, bus.ovf} !== {3'b100, {W{1'b0}}, 2'b00}) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b v=%b busy=%b s=%h c=%b o=%b required 1 0 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, bus.ovf);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      accept(32'h000000FF, 32'h00000001, 1'b0, mk(32'h00000100, 1'b0, 1'b0));
      collect(0);
      accept(32'hFFFFFFFF, 32'h00000001, 1'b0, mk(32'h00000000, 1'b1, 1'b0));
      collect(0);
      accept(32'h7FFFFFFF, 32'h00000001, 1'b0, mk(32'h80000000, 1'b0, 1'b1));
      collect(0);
   endtask

   task automatic test_sub();
      accept(32'd5, 32'd7, 1'b1, mk(32'hFFFFFFFE, 1'b0, 1'b0));
      collect(0);
      accept(32'd7, 32'd5, 1'b1, mk(32'h00000002, 1'b1, 1'b0));
      collect(0);
      accept(32'h80000000, 32'd1, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b1));
      collect(0);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] na, nb;
      na = 32'h12345678;
      nb = 32'h0FEDCBA9;
      accept(32'h00FF00FF, 32'h00010001, 1'b0, mk(32'h01000100, 1'b0, 1'b0));
      // New request held while busy, with operands differing from the latched ones.
      bus.in_valid = 1'b1;
      bus.a        = na;
      bus.b        = nb;
      bus.op_sub   = 1'b1;
      collect(3);
      accept(na, nb, 1'b1, model(na, nb, 1'b1));
      collect(0);
   endtask

   task automatic test_ready_early();
      bus.out_ready = 1'b1;
      accept(32'hDEADBEEF, 32'h21524111, 1'b0, model(32'hDEADBEEF, 32'h21524111, 1'b0));
      bus.out_ready = 1'b1;
      collect(0);
   endtask

   task automatic test_reset_mid();
      exp_t dropped;
      accept(32'hAAAAAAAA, 32'h55555555, 1'b0, mk(32'hFFFFFFFF, 1'b0, 1'b0));
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got %b required 1", bus.busy);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      if (sb.size() != 0) dropped = sb.pop_back();
      checks++;
      if ({bus.busy, bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {3'b010, {W{1'b0}}, 2'b00}) begin
         errors++;
         $display("FAIL mid_reset_state: got busy=%b rdy=%b v=%b s=%h c=%b o=%b required 0 1 0 0 0 0",
                  bus.busy, bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
      end
      repeat (K + 3) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL aborted_result: out_valid=%b required 0", bus.out_valid);
         end
      end
      accept(32'h00000010, 32'h00000020, 1'b1, mk(32'hFFFFFFF0, 1'b0, 1'b0));
      collect(0);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ra, rb;
      logic         rs;
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (i == 0) begin
            ra = 32'h80000000;
            rb = 32'h80000000;
            rs = 1'b0;
         end
         accept(ra, rb, rs, model(ra, rb, rs));
         collect(i % 3);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op_sub    = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_ready_early();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
